if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter TEXT_BASE, default 32'h0000_3000, lowest legal fetch address.
REQ-002 SHALL have parameter TEXT_END, default 32'h0000_6FFC, highest legal fetch address.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction substituted for bubbles and fetch faults.
REQ-004 SHALL have ports as follows, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  active-high hold from the hazard unit.
- flush  input  1  active-high; squash the entry (exception/eret).
- Instr_F  input  32  fetched instruction.
- PC4_F  input  32  fetch PC + 4.
- PC8_F  input  32  fetch PC + 8.
- BJ_D  input  1  instruction currently in ID is a branch/jump.
- Instr_D  output  32  instruction presented to decode.
- PC_D  output  32  PC of Instr_D.
- PC4_D  output  32  PC_D + 4.
- PC8_D  output  32  PC_D + 8.
- BD_D  output  1  Instr_D is in a branch delay slot.
- ExcCode_D  output  5  0 = none, 4 = AdEL (fetch address error).
- Valid_D  output  1  entry holds a real (non-bubble) instruction.
- StallCnt  output  16  count of cycles a valid entry was held.

Function
REQ-005 SHALL compute PC_F = PC4_F - 32'd4, modulo 2^32.
REQ-006 SHALL flag a fetch fault when PC_F[1:0] != 2'b00, when PC_F < TEXT_BASE, or when PC_F > TEXT_END.
REQ-007 SHALL, on load of a faulting fetch, register Instr_D = NOP_INSTR and ExcCode_D = 5'd4, with PC_D/PC4_D/PC8_D holding the faulting PC values and Valid_D = 1.
REQ-008 SHALL, on load of a non-faulting fetch, register Instr_D = Instr_F, PC_D = PC_F, PC4_D = PC4_F, PC8_D = PC8_F, ExcCode_D = 0 and Valid_D = 1.
REQ-009 SHALL register BD_D = BJ_D on every load.
REQ-010 SHALL apply per-edge priority reset > flush > stall > load.
REQ-011 SHALL implement a 2-bit FSM with states EMPTY (bubble), VALID (fresh entry) and HELD (valid entry frozen by stall).
REQ-012 SHALL make these FSM transitions:
- flush from any state -> EMPTY.
- stall from EMPTY -> EMPTY.
- stall from VALID or HELD -> HELD.
- no stall and no flush from any state -> VALID via load.
REQ-013 SHALL, on flush, clear the entry: Instr_D = NOP_INSTR, BD_D = 0, ExcCode_D = 0, Valid_D = 0, PC fields = 0.
REQ-014 SHALL flush when flush and stall are asserted in the same cycle; the flush wins.
REQ-015 SHALL hold all outputs bit-exact while stall = 1 and flush = 0.
REQ-016 SHALL increment StallCnt by 1 on each edge where stall = 1, flush = 0 and the state is VALID or HELD.
REQ-017 SHALL saturate StallCnt at 16'hFFFF, with no wrap-around.
REQ-018 SHALL make all outputs direct register outputs, with one-cycle latency from F inputs to D outputs.

Reset
REQ-019 SHALL, while reset = 0, asynchronously force: state = EMPTY, Instr_D = NOP_INSTR, PC_D = PC4_D = PC8_D = 0, BD_D = 0, ExcCode_D = 0, Valid_D = 0, StallCnt = 0.
REQ-020 SHALL, when reset asserts mid-stall, lose the held entry and restart in EMPTY; the first edge after release with stall = 0 SHALL perform a normal load.

Structure
REQ-021 SHALL place the ExcCode constants (EXC_NONE = 0, EXC_ADEL = 4), the NOP encoding and the FSM state encodings in the shared pipeline package.
REQ-022 SHALL contain one natural sub-module, fetch_exc_check: a combinational PC fault detector, parameterised by TEXT_BASE and TEXT_END, returning fault and ExcCode.

Verification
REQ-023 Normal load: PC4_F = 0x3004, Instr_F = 0x3C010001, BJ_D = 0 -> next edge PC_D = 0x3000, Instr_D = 0x3C010001, Valid_D = 1, ExcCode_D = 0.
REQ-024 Misaligned fetch: PC4_F = 0x3006 -> Instr_D = 0, ExcCode_D = 4, PC_D = 0x3002, Valid_D = 1.
REQ-025 Out of range: PC4_F = 0x7004 (PC 0x7000) -> ExcCode_D = 4; PC4_F = 0x7000 (PC 0x6FFC) -> ExcCode_D = 0.
REQ-026 Delay slot and stall: load with BJ_D = 1, then stall = 1 for 3 cycles with changing F inputs -> BD_D = 1 and all outputs unchanged; StallCnt = 3; state HELD.
REQ-027 Flush with stall: flush = 1 and stall = 1 in the same cycle while HELD -> Valid_D = 0, Instr_D = 0, BD_D = 0; StallCnt not incremented.
REQ-028 Async reset mid-HELD: drive reset low between edges -> outputs immediately at their reset values; StallCnt preloaded near 0xFFFF saturates at 0xFFFF before reset and reads 0 after it.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline definitions for the IF/ID boundary: exception codes,
// the NOP encoding, the FSM state encoding and the registered entry layout.
package if_id_reg_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP_ENC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // bubble
    ST_VALID = 2'b01,  // fresh entry loaded this edge
    ST_HELD  = 2'b10   // valid entry frozen by stall
  } if_id_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } if_id_entry_t;

endpackage : if_id_reg_pkg

// File: rtl/if_id_reg_fetch_exc_check.sv
// Combinational fetch-address fault detector: flags a misaligned PC or one
// outside the legal text window and reports the matching exception code.
module fetch_exc_check
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC
) (
  input  logic [31:0] pc_i,
  output logic        fault_o,
  output logic [4:0]  exc_code_o
);

  // Fault on misalignment or on either side of the text window.
  always_comb begin
    fault_o    = (pc_i[1:0] != 2'b00) || (pc_i < TEXT_BASE) || (pc_i > TEXT_END);
    exc_code_o = fault_o ? EXC_ADEL : EXC_NONE;
  end

endmodule : fetch_exc_check

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with fetch-fault tagging, bubble/flush handling,
// stall hold and a saturating count of cycles a valid entry was held.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC4_F,
  input  logic [31:0] PC8_F,
  input  logic        BJ_D,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic [31:0] PC8_D,
  output logic        BD_D,
  output logic [4:0]  ExcCode_D,
  output logic        Valid_D,
  output logic [15:0] StallCnt
);

  if_id_state_e state_q, state_d;
  if_id_entry_t entry_q, entry_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_f;
  logic        fetch_fault;
  logic [4:0]  fetch_exc;

  // Bubble contents used both by reset and by flush.
  function automatic if_id_entry_t bubble_entry();
    if_id_entry_t e;
    e       = '0;
    e.instr = NOP_INSTR;
    e.exc   = EXC_NONE;
    return e;
  endfunction

  assign pc_f = PC4_F - 32'd4;

  fetch_exc_check #(
    .TEXT_BASE (TEXT_BASE),
    .TEXT_END  (TEXT_END)
  ) u_fetch_exc_check (
    .pc_i       (pc_f),
    .fault_o    (fetch_fault),
    .exc_code_o (fetch_exc)
  );

  // Next state, next entry and next stall count; priority flush > stall > load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    entry_d     = entry_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      state_d = ST_EMPTY;
      entry_d = bubble_entry();
    end else if (stall) begin
      // A bubble stays a bubble; only a real entry becomes HELD and is counted.
      if (state_q != ST_EMPTY) begin
        state_d = ST_HELD;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      state_d       = ST_VALID;
      entry_d.instr = fetch_fault ? NOP_INSTR : Instr_F;
      entry_d.pc    = pc_f;
      entry_d.pc4   = PC4_F;
      entry_d.pc8   = PC8_F;
      entry_d.bd    = BJ_D;
      entry_d.exc   = fetch_exc;
      entry_d.valid = 1'b1;
    end
  end

  // State, entry and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      entry_q     <= bubble_entry();
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q     <= state_d;
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Instr_D   = entry_q.instr;
  assign PC_D      = entry_q.pc;
  assign PC4_D     = entry_q.pc4;
  assign PC8_D     = entry_q.pc8;
  assign BD_D      = entry_q.bd;
  assign ExcCode_D = entry_q.exc;
  assign Valid_D   = entry_q.valid;
  assign StallCnt  = stall_cnt_q;

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] Instr_F;
  logic [31:0] PC4_F;
  logic [31:0] PC8_F;
  logic        BJ_D;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC4_D;
  logic [31:0] PC8_D;
  logic        BD_D;
  logic [4:0]  ExcCode_D;
  logic        Valid_D;
  logic [15:0] StallCnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_cnt = 16'd0;

  if_id_reg dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .Instr_F   (Instr_F),
    .PC4_F     (PC4_F),
    .PC8_F     (PC8_F),
    .BJ_D      (BJ_D),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC4_D     (PC4_D),
    .PC8_D     (PC8_D),
    .BD_D      (BD_D),
    .ExcCode_D (ExcCode_D),
    .Valid_D   (Valid_D),
    .StallCnt  (StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [31:0] instr, input logic [31:0] pc4, input logic bj);
    Instr_F = instr;
    PC4_F   = pc4;
    PC8_F   = pc4 + 32'd4;
    BJ_D    = bj;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (Instr_D !== 32'h0) $display("FAIL reset_instr got %h exp %h", Instr_D, 32'h0); else n_pass++;
    n_total++; if ({PC_D, PC4_D, PC8_D} !== 96'h0) $display("FAIL reset_pcs got %h %h %h exp 0", PC_D, PC4_D, PC8_D); else n_pass++;
    n_total++; if ({Valid_D, BD_D, ExcCode_D} !== 7'h0) $display("FAIL reset_flags got v%b bd%b exc%0d exp 0", Valid_D, BD_D, ExcCode_D); else n_pass++;
    n_total++; if (StallCnt !== 16'h0) $display("FAIL reset_cnt got %h exp 0", StallCnt); else n_pass++;
    #1 reset = 1'b1;
  endtask

  task automatic test_normal_load();
    drive_f(32'h3C01_0001, 32'h0000_3004, 1'b0);
    step();
    n_total++; if (PC_D !== 32'h3000) $display("FAIL load_pc got %h exp %h", PC_D, 32'h3000); else n_pass++;
    n_total++; if (Instr_D !== 32'h3C01_0001) $display("FAIL load_instr got %h exp %h", Instr_D, 32'h3C01_0001); else n_pass++;
    n_total++; if ({PC4_D, PC8_D} !== {32'h3004, 32'h3008}) $display("FAIL load_pc48 got %h %h exp 3004 3008", PC4_D, PC8_D); else n_pass++;
    n_total++; if ({Valid_D, BD_D, ExcCode_D} !== {1'b1, 1'b0, 5'd0}) $display("FAIL load_flags got v%b bd%b exc%0d exp v1 bd0 exc0", Valid_D, BD_D, ExcCode_D); else n_pass++;
  endtask

  task automatic test_misaligned();
    drive_f(32'hDEAD_BEEF, 32'h0000_3006, 1'b0);
    step();
    n_total++; if (Instr_D !== 32'h0) $display("FAIL misal_instr got %h exp 0", Instr_D); else n_pass++;
    n_total++; if (ExcCode_D !== 5'd4) $display("FAIL misal_exc got %0d exp 4", ExcCode_D); else n_pass++;
    n_total++; if ({PC_D, PC4_D, PC8_D} !== {32'h3002, 32'h3006, 32'h300A}) $display("FAIL misal_pcs got %h %h %h exp 3002 3006 300a", PC_D, PC4_D, PC8_D); else n_pass++;
    n_total++; if (Valid_D !== 1'b1) $display("FAIL misal_valid got %b exp 1", Valid_D); else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] pc4_vec [4] = '{32'h7004, 32'h7000, 32'h3000, 32'h0000};
    logic [4:0]  exc_vec [4] = '{5'd4, 5'd0, 5'd4, 5'd4};
    for (int i = 0; i < 4; i++) begin
      drive_f(32'h1234_0000 + 32'(i), pc4_vec[i], 1'b0);
      step();
      n_total++;
      if (ExcCode_D !== exc_vec[i]) $display("FAIL range_exc[%0d] got %0d exp %0d", i, ExcCode_D, exc_vec[i]);
      else n_pass++;
      n_total++;
      if (PC_D !== pc4_vec[i] - 32'd4) $display("FAIL range_pc[%0d] got %h exp %h", i, PC_D, pc4_vec[i] - 32'd4);
      else n_pass++;
    end
    // The in-range edge case must pass its instruction through.
    drive_f(32'hCAFE_0001, 32'h7000, 1'b0);
    step();
    n_total++; if (Instr_D !== 32'hCAFE_0001) $display("FAIL range_end_instr got %h exp cafe0001", Instr_D); else n_pass++;
  endtask

  task automatic test_delay_slot_stall();
    drive_f(32'h1111_2222, 32'h0000_4004, 1'b1);
    step();
    n_total++; if (BD_D !== 1'b1) $display("FAIL bd_load got %b exp 1", BD_D); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_f(32'h9999_0000 + 32'(i), 32'h0000_5000 + 32'(8 * i), i[0]);
      step();
      exp_cnt++;
      n_total++;
      if ({Instr_D, PC_D, PC4_D, PC8_D, BD_D, ExcCode_D, Valid_D} !==
          {32'h1111_2222, 32'h4000, 32'h4004, 32'h4008, 1'b1, 5'd0, 1'b1})
        $display("FAIL stall_hold[%0d] got %h %h %h %h %b %0d %b", i, Instr_D, PC_D, PC4_D, PC8_D, BD_D, ExcCode_D, Valid_D);
      else n_pass++;
    end
    n_total++; if (StallCnt !== 16'd3) $display("FAIL stall_cnt got %0d exp 3", StallCnt); else n_pass++;
    n_total++; if (dut.state_q !== ST_HELD) $display("FAIL stall_state got %0d exp %0d", dut.state_q, ST_HELD); else n_pass++;
  endtask

  task automatic test_flush_with_stall();
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    n_total++; if ({Valid_D, BD_D, ExcCode_D} !== 7'h0) $display("FAIL flush_flags got v%b bd%b exc%0d exp 0", Valid_D, BD_D, ExcCode_D); else n_pass++;
    n_total++; if ({Instr_D, PC_D, PC4_D, PC8_D} !== 128'h0) $display("FAIL flush_fields got %h %h %h %h exp 0", Instr_D, PC_D, PC4_D, PC8_D); else n_pass++;
    n_total++; if (StallCnt !== exp_cnt) $display("FAIL flush_cnt got %0d exp %0d", StallCnt, exp_cnt); else n_pass++;
    // Stalling an empty entry neither counts nor revives it.
    step();
    step();
    n_total++; if ({Valid_D, StallCnt} !== {1'b0, exp_cnt}) $display("FAIL empty_stall got v%b cnt %0d exp v0 cnt %0d", Valid_D, StallCnt, exp_cnt); else n_pass++;
    stall = 1'b0;
  endtask

  task automatic test_saturate_and_reset();
    drive_f(32'h2222_3333, 32'h0000_6004, 1'b0);
    step();
    stall = 1'b1;
    while (exp_cnt != 16'hFFFE) begin
      step();
      exp_cnt++;
    end
    n_total++; if (StallCnt !== 16'hFFFE) $display("FAIL sat_pre got %h exp fffe", StallCnt); else n_pass++;
    for (int i = 0; i < 5; i++) step();
    n_total++; if (StallCnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", StallCnt); else n_pass++;
    n_total++; if (Instr_D !== 32'h2222_3333) $display("FAIL sat_entry got %h exp 22223333", Instr_D); else n_pass++;
    // Assert reset between edges; outputs must clear without waiting for clk.
    #2 reset = 1'b0;
    #1;
    n_total++; if ({Valid_D, Instr_D, PC_D} !== 65'h0) $display("FAIL areset_fields got v%b %h %h exp 0", Valid_D, Instr_D, PC_D); else n_pass++;
    n_total++; if (StallCnt !== 16'h0) $display("FAIL areset_cnt got %h exp 0", StallCnt); else n_pass++;
    n_total++; if (dut.state_q !== ST_EMPTY) $display("FAIL areset_state got %0d exp %0d", dut.state_q, ST_EMPTY); else n_pass++;
    #1 reset = 1'b1;
    stall = 1'b0;
    drive_f(32'hAAAA_5555, 32'h0000_5004, 1'b0);
    step();
    n_total++; if ({Instr_D, PC_D, Valid_D} !== {32'hAAAA_5555, 32'h5000, 1'b1}) $display("FAIL post_reset_load got %h %h v%b", Instr_D, PC_D, Valid_D); else n_pass++;
    n_total++; if (StallCnt !== 16'h0) $display("FAIL post_reset_cnt got %h exp 0", StallCnt); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_f(32'h0, 32'h0, 1'b0);
    test_reset();
    test_normal_load();
    test_misaligned();
    test_range();
    test_delay_slot_stall();
    test_flush_with_stall();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_if_id_reg
